nullify_ctrl: RTL and testbench
===============================

Name: nullify_ctrl

Overview:
- Execute-stage condition evaluator and nullification tracker; the consumer side of the PSW carry/nullify state.
- Each cycle it supplies the stored PSW carry to the ALU as carry-in for ADDC/SUBB-class instructions.
- It evaluates the PA-RISC compare/add condition on the ALU flags. When the condition is true and the n-bit is set, it arms nullification of the next valid instruction to reach EX.
- It counts nullified instructions for performance monitoring.

Parameters:
- CNT_W, 8, width of the saturating nullified-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- Co  in  1  stored PSW carry bit.
- use_carry  in  1  EX instruction consumes carry (ADDC/SUBB class).
- ex_valid  in  1  EX stage holds a real instruction (0 = bubble).
- ex_is_cond  in  1  EX instruction carries a condition field.
- ex_c  in  3  condition field c.
- ex_f  in  1  negate-condition bit.
- ex_n  in  1  nullify bit of the EX instruction.
- Z, N, V, C_B  in  1 each  ALU zero, negative, overflow, carry flags of the EX result.
- res_lsb  in  1  bit 0 of the ALU result.
- stall  in  1  pipeline hold; EX does not advance.
- flush  in  1  squash of younger instructions (taken branch or exception).
- cnt_clr  in  1  synchronous clear of null_count.
- carry_in  out  1  ALU carry-in (combinational).
- cond_true  out  1  evaluated condition (combinational).
- ex_kill  out  1  current EX instruction is nullified (combinational).
- armed  out  1  registered pending-nullification flag.
- null_count  out  CNT_W  saturating count of killed instructions.

Behaviour:
- Reset (Reset=0, async): armed=0, null_count=0. Outputs derived from armed (ex_kill) are 0.
- carry_in = use_carry & Co. Otherwise 0. No latency.
- Raw condition by ex_c:
  - 0 never = 0.
  - 1 "=" = Z.
  - 2 "<" = N^V.
  - 3 "<=" = (N^V)|Z.
  - 4 "<<" = ~C_B.
  - 5 "<<=" = ~C_B|Z.
  - 6 SV = V.
  - 7 OD = res_lsb.
- cond_true = ex_is_cond & (raw ^ ex_f). It is 0 when ex_is_cond=0.
- ex_kill = armed & ex_valid.
- A killed instruction never generates nullification: its cond_true is still driven, but it is ignored for arming.
- nullify_req = ex_valid & ~ex_kill & ex_is_cond & ex_n & cond_true.
- Two-state FSM on armed, transitions at the rising clk edge, in priority order:
  - flush=1 -> IDLE. Flush wins over every other event, including stall and a same-cycle nullify_req.
  - stall=1 -> hold state. No counter update.
  - IDLE: nullify_req -> ARMED; otherwise stay IDLE.
  - ARMED: ex_valid=1 -> the instruction is killed this cycle. The state then goes IDLE, because a killed instruction cannot re-arm.
  - ARMED: ex_valid=0 (bubble) -> stay ARMED. Nullification applies to the next real instruction.
- Latency: nullify_req in cycle t kills the first valid EX instruction at cycle >= t+1 that is not stalled.
- null_count increments by 1 on each advancing cycle (stall=0, flush=0) with ex_kill=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 forces 0 and has priority over increment.
  - The counter keeps operating during flush cycles except for the increment.
- An async reset mid-ARMED drops the pending nullification immediately. No kill occurs after reset release.

Decomposition:
- Shared package: the condition encodings (COND_NEVER..COND_OD, 3-bit) and the FSM state encoding (NS_IDLE=0, NS_ARMED=1).
- One natural sub-module: cond_eval. It is purely combinational: ex_c, ex_f, Z, N, V, C_B, res_lsb -> raw condition.
- The FSM and the counter stay in nullify_ctrl.

Test Plan:
- Reset: assert Reset=0 mid-ARMED -> armed=0, null_count=0 immediately. After release, the next valid instruction has ex_kill=0.
- Carry path: Co=1, use_carry=1 -> carry_in=1. use_carry=0 -> carry_in=0. Co=0 -> carry_in=0.
- Condition sweep: c=2 with N=1, V=0 -> cond_true=1. Same with f=1 -> 0. c=4 with C_B=1 -> 0. c=7 with res_lsb=1 -> 1. c=0 -> always 0.
- Nullify chain:
  - Instr A has c=1, Z=1, n=1 -> armed=1 next cycle.
  - A bubble follows -> armed stays 1.
  - Instr B valid -> ex_kill=1 and null_count=1; armed=0 after.
  - B is itself nullifying -> it does not re-arm.
- Stall/flush:
  - armed=1 with stall=1 for 3 cycles -> armed held, ex_kill stays 1, count unchanged.
  - flush together with nullify_req -> armed=0.
- Counter: CNT_W=2, kill 5 instructions -> null_count=3 (saturated). Then cnt_clr=1 coincident with a kill -> 0.

Source files
------------

// File: rtl/nullify_ctrl_pkg.sv
// Shared encodings for the EX-stage condition evaluator and nullification tracker.
package nullify_ctrl_pkg;

  typedef enum logic [2:0] {
    COND_NEVER = 3'd0,
    COND_EQ    = 3'd1,
    COND_LT    = 3'd2,
    COND_LE    = 3'd3,
    COND_LTU   = 3'd4,
    COND_LEU   = 3'd5,
    COND_SV    = 3'd6,
    COND_OD    = 3'd7
  } cond_e;

  typedef enum logic {
    NS_IDLE  = 1'b0,
    NS_ARMED = 1'b1
  } ns_state_e;

endpackage

// File: rtl/nullify_ctrl_cond_eval.sv
// Combinational PA-RISC compare/add condition: selects a flag term by c, then applies f.
module cond_eval
  import nullify_ctrl_pkg::*;
(
  input  logic [2:0] ex_c,
  input  logic       ex_f,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  input  logic       C_B,
  input  logic       res_lsb,
  output logic       cond
);

  logic raw;

  always_comb begin
    raw = 1'b0;
    case (cond_e'(ex_c))
      COND_NEVER: raw = 1'b0;
      COND_EQ:    raw = Z;
      COND_LT:    raw = N ^ V;
      COND_LE:    raw = (N ^ V) | Z;
      COND_LTU:   raw = ~C_B;
      COND_LEU:   raw = ~C_B | Z;
      COND_SV:    raw = V;
      COND_OD:    raw = res_lsb;
      default:    raw = 1'b0;
    endcase
  end

  assign cond = raw ^ ex_f;

endmodule

// File: rtl/nullify_ctrl.sv
// EX-stage carry-in supply, condition evaluation, and pending-nullification tracker
// with a saturating count of killed instructions.
module nullify_ctrl
  import nullify_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Co,
  input  logic             use_carry,
  input  logic             ex_valid,
  input  logic             ex_is_cond,
  input  logic [2:0]       ex_c,
  input  logic             ex_f,
  input  logic             ex_n,
  input  logic             Z,
  input  logic             N,
  input  logic             V,
  input  logic             C_B,
  input  logic             res_lsb,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             carry_in,
  output logic             cond_true,
  output logic             ex_kill,
  output logic             armed,
  output logic [CNT_W-1:0] null_count
);

  ns_state_e state, state_nxt;
  logic      cond;
  logic      nullify_req;

  cond_eval u_cond_eval (
    .ex_c    (ex_c),
    .ex_f    (ex_f),
    .Z       (Z),
    .N       (N),
    .V       (V),
    .C_B     (C_B),
    .res_lsb (res_lsb),
    .cond    (cond)
  );

  assign carry_in  = use_carry & Co;
  assign cond_true = ex_is_cond & cond;

  // A killed instruction still drives cond_true but must never arm.
  assign nullify_req = ex_valid & ~ex_kill & ex_is_cond & ex_n & cond_true;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= NS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = NS_IDLE;
    end else if (!stall) begin
      case (state)
        NS_IDLE:  if (nullify_req) state_nxt = NS_ARMED;
        NS_ARMED: if (ex_valid)    state_nxt = NS_IDLE;
        default:  state_nxt = NS_IDLE;
      endcase
    end
  end

  always_comb begin
    armed   = (state == NS_ARMED);
    ex_kill = armed & ex_valid;
  end

  // Clear wins over everything; increments only on advancing, non-flushed kills.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)
      null_count <= '0;
    else if (cnt_clr)
      null_count <= '0;
    else if (!stall && !flush && ex_kill && (null_count != {CNT_W{1'b1}}))
      null_count <= null_count + 1'b1;
  end

endmodule

// File: tb/tb_nullify_ctrl.sv
// Directed plus random checking of nullify_ctrl against a flag-table/pending-bit model.
module tb_nullify_ctrl;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Co, use_carry, ex_valid, ex_is_cond, ex_f, ex_n;
  logic             Z, N, V, C_B, res_lsb, stall, flush, cnt_clr;
  logic [2:0]       ex_c;
  logic             carry_in, cond_true, ex_kill, armed;
  logic [CNT_W-1:0] null_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit m_armed;
  int m_cnt;

  always #5 clk = ~clk;

  nullify_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .Reset(Reset), .Co(Co), .use_carry(use_carry),
    .ex_valid(ex_valid), .ex_is_cond(ex_is_cond), .ex_c(ex_c), .ex_f(ex_f),
    .ex_n(ex_n), .Z(Z), .N(N), .V(V), .C_B(C_B), .res_lsb(res_lsb),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .carry_in(carry_in), .cond_true(cond_true), .ex_kill(ex_kill),
    .armed(armed), .null_count(null_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Condition as a lookup over the eight flag terms, indexed by c.
  function automatic bit m_cond();
    bit [7:0] tbl;
    tbl = {res_lsb, V, ~C_B | Z, ~C_B, (N ^ V) | Z, N ^ V, Z, 1'b0};
    return ex_is_cond & (tbl[ex_c] ^ ex_f);
  endfunction

  task automatic idle_in();
    Co = 0; use_carry = 0; ex_valid = 0; ex_is_cond = 0; ex_c = 3'd0; ex_f = 0;
    ex_n = 0; Z = 0; N = 0; V = 0; C_B = 0; res_lsb = 0;
    stall = 0; flush = 0; cnt_clr = 0;
  endtask

  task automatic rand_in();
    Co = 1'($urandom); use_carry = 1'($urandom);
    ex_valid = ($urandom_range(3) != 0); ex_is_cond = ($urandom_range(3) != 0);
    ex_c = 3'($urandom); ex_f = 1'($urandom); ex_n = 1'($urandom);
    Z = 1'($urandom); N = 1'($urandom); V = 1'($urandom); C_B = 1'($urandom);
    res_lsb = 1'($urandom);
    stall = ($urandom_range(3) == 0); flush = ($urandom_range(7) == 0);
    cnt_clr = ($urandom_range(15) == 0);
  endtask

  // Inputs are set at negedge; check outputs, then advance the model across posedge.
  task automatic tick();
    bit cond, kill, req;
    #1;
    cond = m_cond();
    kill = m_armed & ex_valid;
    req  = ex_valid & ~kill & ex_is_cond & ex_n & cond;
    chk("carry_in",   32'(carry_in),   32'(use_carry & Co));
    chk("cond_true",  32'(cond_true),  32'(cond));
    chk("ex_kill",    32'(ex_kill),    32'(kill));
    chk("armed",      32'(armed),      32'(m_armed));
    chk("null_count", 32'(null_count), 32'(m_cnt));
    @(posedge clk);
    if (flush)       m_armed = 1'b0;
    else if (!stall) m_armed = m_armed ? !ex_valid : req;
    if (cnt_clr) m_cnt = 0;
    else if (!stall && !flush && kill && m_cnt < CMAX) m_cnt++;
    @(negedge clk);
  endtask

  task automatic arm_instr();
    idle_in();
    ex_valid = 1; ex_is_cond = 1; ex_c = 3'd1; Z = 1; ex_n = 1;
  endtask

  initial begin
    idle_in();
    ex_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_cnt",   32'(null_count), 32'd0);
    chk("rst_kill",  32'(ex_kill), 32'd0);
    m_armed = 0; m_cnt = 0;
    @(negedge clk);
    Reset = 1;

    // Carry path
    idle_in(); Co = 1; use_carry = 1; tick();
    chk("carry_11", 32'(carry_in), 32'd1);
    use_carry = 0; tick();
    Co = 0; use_carry = 1; tick();

    // Condition sweep
    idle_in(); ex_is_cond = 1; ex_c = 3'd2; N = 1; tick();
    ex_f = 1; tick();
    idle_in(); ex_is_cond = 1; ex_c = 3'd4; C_B = 1; tick();
    idle_in(); ex_is_cond = 1; ex_c = 3'd7; res_lsb = 1; tick();
    idle_in(); ex_is_cond = 1; ex_c = 3'd0; Z = 1; N = 1; V = 1; tick();

    // Nullify chain: A arms, bubble holds, B (itself nullifying) killed without re-arming
    arm_instr(); tick();
    chk("chain_armed", 32'(armed), 32'd1);
    idle_in(); tick();
    arm_instr(); tick();
    chk("chain_cnt",   32'(null_count), 32'd1);
    chk("chain_rearm", 32'(armed), 32'd0);

    // Stall holds the kill; flush beats a same-cycle nullify_req
    arm_instr(); tick();
    idle_in(); ex_valid = 1; stall = 1;
    repeat (3) tick();
    chk("stall_armed", 32'(armed), 32'd1);
    stall = 0; tick();
    arm_instr(); flush = 1; tick();
    chk("flush_armed", 32'(armed), 32'd0);

    // Counter saturation, then clear coincident with a kill
    idle_in(); cnt_clr = 1; tick();
    for (int i = 0; i < 5; i++) begin
      arm_instr(); tick();
      idle_in(); ex_valid = 1; tick();
    end
    chk("sat_cnt", 32'(null_count), CMAX);
    arm_instr(); tick();
    idle_in(); ex_valid = 1; cnt_clr = 1; tick();
    chk("clr_cnt", 32'(null_count), 32'd0);

    // Async reset mid-ARMED
    arm_instr(); tick();
    idle_in(); ex_valid = 1;
    #2 Reset = 0;
    #1;
    chk("arst_armed", 32'(armed), 32'd0);
    chk("arst_kill",  32'(ex_kill), 32'd0);
    m_armed = 0; m_cnt = 0;
    @(negedge clk);
    Reset = 1;
    tick();

    for (int i = 0; i < 2000; i++) begin
      rand_in();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
